// File: rtl/mod_seq.sv
// mod_seq: sequencer that issues jobs to the mod engine and returns tagged results
// clk, rst_n           : clock, async active-low reset
// req_*                : job request channel (valid/ready, a, b, tag)
// rsp_*                : result channel (valid/ready, res, tag, err 0=ok 1=div0 2=timeout)
// mod_start/a/b        : engine start pulse and operands; mod_res/mod_valid from engine
// busy                 : not idle; done_cnt/err_cnt : handed-off responses / errored responses
module mod_seq #(
  parameter int W       = 128,
  parameter int TAGW    = 4,
  parameter int TIMEOUT = 1024,
  parameter int CNTW    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [W-1:0]    req_a,
  input  logic [W-1:0]    req_b,
  input  logic [TAGW-1:0] req_tag,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [W-1:0]    rsp_res,
  output logic [TAGW-1:0] rsp_tag,
  output logic [1:0]      rsp_err,
  output logic            mod_start,
  output logic [W-1:0]    mod_a,
  output logic [W-1:0]    mod_b,
  input  logic [W-1:0]    mod_res,
  input  logic            mod_valid,
  output logic            busy,
  output logic [CNTW-1:0] done_cnt,
  output logic [CNTW-1:0] err_cnt
);
  localparam int TW = $clog2(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [TW-1:0] cnt;
  logic          expired;
  // cnt counts cycles since ISSUE, so a timeout lands TIMEOUT cycles after the start pulse
  assign expired   = cnt == TW'(TIMEOUT - 1);
  assign req_ready = state == IDLE;
  assign busy      = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = !req_valid ? IDLE : (req_b == '0 ? RESP : ISSUE);
      ISSUE: state_n = WAIT;
      WAIT:  state_n = (mod_valid || expired) ? RESP : WAIT;
      RESP:  state_n = rsp_ready ? IDLE : RESP;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mod_start <= 1'b0;
      mod_a     <= '0;
      mod_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_res   <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 2'd0;
      done_cnt  <= '0;
      err_cnt   <= '0;
    end else begin
      state     <= state_n;
      cnt       <= (state == ISSUE || state == WAIT) ? cnt + 1'b1 : '0;
      mod_start <= state_n == ISSUE;
      rsp_valid <= state_n == RESP;
      if (state == IDLE && req_valid) begin
        rsp_tag <= req_tag;
        if (req_b == '0) begin
          rsp_res <= '0;
          rsp_err <= 2'd1;
        end else begin
          mod_a <= req_a;
          mod_b <= req_b;
        end
      end
      // a result arriving on the last wait cycle wins over the timeout
      if (state == WAIT && mod_valid) begin
        rsp_res <= mod_res;
        rsp_err <= 2'd0;
      end else if (state == WAIT && expired) begin
        rsp_res <= '0;
        rsp_err <= 2'd2;
      end
      if (state == RESP && rsp_ready) begin
        done_cnt <= done_cnt + 1'b1;
        err_cnt  <= err_cnt + CNTW'(rsp_err != 2'd0);
      end
    end
  end
endmodule

// File: doc/mod_seq.md
Name: mod_seq

Overview:
- Initiator/sequencer that drives the 128-bit `mod` reduction engine through its start/valid interface.
- Accepts operand jobs on a valid/ready request channel, guards divide-by-zero locally, pulses `mod_start`, and waits for `mod_valid` under a timeout.
- Returns tagged results on a valid/ready response channel.
- Sits between PoH simulation control logic and the `mod` engine, replacing ad-hoc start/poll sequencing.

Parameters:
- W, 128, operand/result width; must match the `mod` engine.
- TAGW, 4, width of the request tag echoed on the response.
- TIMEOUT, 1024, maximum WAIT cycles before declaring a timeout; must be ≥ 2.
- CNTW, 32, width of the statistics counters.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  job offered.
- req_ready  out  1  block can accept a job; high only in IDLE.
- req_a  in  W  dividend.
- req_b  in  W  divisor.
- req_tag  in  TAGW  job tag.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_res  out  W  req_a % req_b, or 0 on error.
- rsp_tag  out  TAGW  tag of the completed job.
- rsp_err  out  2  0 = ok, 1 = divide-by-zero, 2 = timeout.
- mod_start  out  1  one-cycle start pulse to the engine.
- mod_a  out  W  dividend to the engine.
- mod_b  out  W  divisor to the engine.
- mod_res  in  W  engine result.
- mod_valid  in  1  engine result valid.
- busy  out  1  state != IDLE.
- done_cnt  out  CNTW  responses handed off (all rsp_err values).
- err_cnt  out  CNTW  responses handed off with rsp_err != 0.

Behaviour:
- Reset (async, rst_n low):
  - state = IDLE.
  - Zero: mod_start, rsp_valid, rsp_res, rsp_tag, rsp_err, mod_a, mod_b, done_cnt, err_cnt, timeout counter.
  - busy = 0. req_ready = 1 once rst_n is high.
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are registered except req_ready and busy, which decode state.
- IDLE:
  - On req_valid & req_ready, capture a, b and tag.
  - If b == 0: go to RESP with rsp_res = 0, rsp_err = 1; the engine is not started.
  - Otherwise: load mod_a/mod_b and go to ISSUE.
  - mod_valid is ignored in IDLE.
- ISSUE:
  - mod_start = 1 for exactly this cycle.
  - Clear the timeout counter and go to WAIT.
  - mod_valid sampled in ISSUE is ignored, because it may be stale from the previous job.
- WAIT:
  - mod_start = 0. mod_a/mod_b are held stable from ISSUE through WAIT.
  - Counter increments each cycle.
  - If mod_valid = 1: register rsp_res = mod_res, rsp_err = 0, go to RESP.
  - Else if counter == TIMEOUT-1: rsp_res = 0, rsp_err = 2, go to RESP.
  - mod_valid has priority over timeout when both occur in the same cycle.
- RESP:
  - rsp_valid = 1; rsp_res, rsp_tag and rsp_err are held stable until rsp_ready.
  - On handshake: go to IDLE, rsp_valid = 0 next cycle, done_cnt += 1, err_cnt += (rsp_err != 0).
  - req_ready = 0 in RESP; no overlap between jobs.
- Latency:
  - Accept at edge k → mod_start high in cycle k+1 → first qualifying mod_valid at edge k+2 → rsp_valid from cycle k+3.
  - Divide-by-zero: rsp_valid from cycle k+1.
- Counters wrap modulo 2^CNTW without saturation.
- Reset mid-operation: the job is dropped and no response is produced. A late mod_valid from the abandoned engine run arrives in IDLE and is ignored.
- rsp_ready may be high before rsp_valid; the handshake is only counted when both are high at the edge.
- Widths: all operands are unsigned W bits; the block does no arithmetic on data.

Test Plan:
- Engine stub answers 3 cycles after start. Job a=145, b=13, tag=5:
  - mod_start is one cycle wide, mod_a=145, mod_b=13.
  - Response rsp_res=2, rsp_tag=5, rsp_err=0; done_cnt=1, err_cnt=0.
- Job a=1000, b=0, tag=3:
  - mod_start never asserts.
  - rsp_valid in the cycle after acceptance with rsp_res=0, rsp_err=1; err_cnt increments.
- TIMEOUT=16, stub never asserts mod_valid, job a=50, b=7:
  - rsp_err=2, rsp_res=0.
  - rsp_valid appears 16 cycles after the ISSUE cycle.
- Stub holds mod_valid high continuously. Two back-to-back jobs a=145/b=13 then a=1000/b=7, with rsp_ready low for 5 cycles on the first:
  - Responses are 2 then 6, each held stable under backpressure.
  - The second job is not accepted until the first handshake; the stale valid in ISSUE is ignored.
- Assert rst_n low during WAIT, then release:
  - All outputs return to reset values and no response is emitted.
  - A late mod_valid is ignored.
  - The next job a=145, b=13 returns 2.
- Stub raises mod_valid exactly on the cycle the counter hits TIMEOUT-1 (TIMEOUT=16): rsp_err=0 and rsp_res=mod_res.
